register_bank_eight_entry: RTL and testbench

- Eight-entry, BITS-wide register bank with one write port and two registered read ports (A, B).
- Sits directly upstream of the datapath's 8:1 operand-select mux.
- Drives the packed 8-entry contents bus consumed by that mux.
- Read ports deliver selected operands one cycle after request, with write-first bypass.

---
 rtl/register_bank_pkg.sv | 10 +
 rtl/EIGHT_N_BITS_INPUTS_THREE_BITS_SELECT_MUX_MODULE.sv | 12 +
 rtl/register_bank_read_port.sv | 52 +++++
 rtl/register_bank_eight_entry.sv | 87 ++++++++
 tb/tb_register_bank_eight_entry.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/register_bank_pkg.sv
// Shared constants and types for the eight-entry register bank.
package register_bank_pkg;

  localparam int unsigned NUM_ENTRIES = 8;
  localparam int unsigned ADDR_BITS   = 3;
  localparam int unsigned COUNT_BITS  = 16;

  typedef logic [ADDR_BITS-1:0] reg_addr_t;

endpackage

// File: rtl/EIGHT_N_BITS_INPUTS_THREE_BITS_SELECT_MUX_MODULE.sv
// Generic 8:1 mux of N-bit inputs selected by a 3-bit code.
module EIGHT_N_BITS_INPUTS_THREE_BITS_SELECT_MUX_MODULE #(
  parameter int unsigned N = 32
) (
  input  logic [7:0][N-1:0] INPUTS,
  input  logic [2:0]        SELECT,
  output logic [N-1:0]      OUTPUT
);

  assign OUTPUT = INPUTS[SELECT];

endmodule

// File: rtl/register_bank_read_port.sv
// One registered read port: entry mux, write-first bypass and output flops.
module register_bank_read_port
  import register_bank_pkg::*;
#(
  parameter int unsigned BITS = 32
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic [NUM_ENTRIES-1:0][BITS-1:0]  i_entries,
  input  logic                              i_wr_commit,
  input  reg_addr_t                         i_wr_addr,
  input  logic [BITS-1:0]                   i_wr_data,
  input  logic                              i_rd_en,
  input  reg_addr_t                         i_rd_addr,
  output logic [BITS-1:0]                   o_rd_data,
  output logic                              o_rd_valid
);

  logic [BITS-1:0] w_mux_data;
  logic [BITS-1:0] w_sel_data;
  logic            w_bypass;
  logic [BITS-1:0] r_rd_data;
  logic            r_rd_valid;

  EIGHT_N_BITS_INPUTS_THREE_BITS_SELECT_MUX_MODULE #(
    .N (BITS)
  ) u_mux (
    .INPUTS (i_entries),
    .SELECT (i_rd_addr),
    .OUTPUT (w_mux_data)
  );

  // Commit already excludes dropped writes, so a hardwired entry 0 never bypasses.
  assign w_bypass   = i_wr_commit && (i_wr_addr == i_rd_addr);
  assign w_sel_data = w_bypass ? i_wr_data : w_mux_data;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        r_rd_data <= w_sel_data;
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/register_bank_eight_entry.sv
// Eight-entry register bank: one write port, two registered read ports,
// packed contents bus and a saturating committed-write counter.
module register_bank_eight_entry
  import register_bank_pkg::*;
#(
  parameter int unsigned BITS               = 32,
  parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic                              WRITE_ENABLE,
  input  reg_addr_t                         WRITE_ADDR,
  input  logic [BITS-1:0]                   WRITE_DATA,
  input  logic                              READ_ENABLE_A,
  input  reg_addr_t                         READ_ADDR_A,
  output logic [BITS-1:0]                   READ_DATA_A,
  output logic                              READ_VALID_A,
  input  logic                              READ_ENABLE_B,
  input  reg_addr_t                         READ_ADDR_B,
  output logic [BITS-1:0]                   READ_DATA_B,
  output logic                              READ_VALID_B,
  output logic [NUM_ENTRIES-1:0][BITS-1:0]  REGISTERS,
  output logic [COUNT_BITS-1:0]             WRITE_COUNT
);

  logic [NUM_ENTRIES-1:0][BITS-1:0] r_entries;
  logic [COUNT_BITS-1:0]            r_write_count;
  logic                             w_commit;

  // Writes to a hardwired entry 0 are dropped entirely, including the count.
  assign w_commit = WRITE_ENABLE &&
                    !(ZERO_REG_HARDWIRED && (WRITE_ADDR == ADDR_BITS'(0)));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_entries <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (w_commit && (WRITE_ADDR == ADDR_BITS'(i))) begin
          r_entries[i] <= WRITE_DATA;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_write_count <= '0;
    end else if (w_commit && (r_write_count != {COUNT_BITS{1'b1}})) begin
      r_write_count <= r_write_count + COUNT_BITS'(1);
    end
  end

  register_bank_read_port #(
    .BITS (BITS)
  ) u_read_port_a (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .i_entries   (r_entries),
    .i_wr_commit (w_commit),
    .i_wr_addr   (WRITE_ADDR),
    .i_wr_data   (WRITE_DATA),
    .i_rd_en     (READ_ENABLE_A),
    .i_rd_addr   (READ_ADDR_A),
    .o_rd_data   (READ_DATA_A),
    .o_rd_valid  (READ_VALID_A)
  );

  register_bank_read_port #(
    .BITS (BITS)
  ) u_read_port_b (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .i_entries   (r_entries),
    .i_wr_commit (w_commit),
    .i_wr_addr   (WRITE_ADDR),
    .i_wr_data   (WRITE_DATA),
    .i_rd_en     (READ_ENABLE_B),
    .i_rd_addr   (READ_ADDR_B),
    .o_rd_data   (READ_DATA_B),
    .o_rd_valid  (READ_VALID_B)
  );

  assign REGISTERS   = r_entries;
  assign WRITE_COUNT = r_write_count;

endmodule

// File: tb/tb_register_bank_eight_entry.sv
// Self-checking bench for register_bank_eight_entry: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_register_bank_eight_entry;

  localparam int unsigned BITS = 32;
  localparam bit          HW   = 1'b1;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             WRITE_ENABLE = 1'b0;
  logic [2:0]       WRITE_ADDR = '0;
  logic [BITS-1:0]  WRITE_DATA = '0;
  logic             READ_ENABLE_A = 1'b0;
  logic [2:0]       READ_ADDR_A = '0;
  logic [BITS-1:0]  READ_DATA_A;
  logic             READ_VALID_A;
  logic             READ_ENABLE_B = 1'b0;
  logic [2:0]       READ_ADDR_B = '0;
  logic [BITS-1:0]  READ_DATA_B;
  logic             READ_VALID_B;
  logic [7:0][BITS-1:0] REGISTERS;
  logic [15:0]      WRITE_COUNT;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [BITS-1:0] m_regs [8];
  int              m_count;
  logic [BITS-1:0] exp_a, exp_b;
  logic            exp_va, exp_vb;

  register_bank_eight_entry #(
    .BITS               (BITS),
    .ZERO_REG_HARDWIRED (HW)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .WRITE_ENABLE  (WRITE_ENABLE),
    .WRITE_ADDR    (WRITE_ADDR),
    .WRITE_DATA    (WRITE_DATA),
    .READ_ENABLE_A (READ_ENABLE_A),
    .READ_ADDR_A   (READ_ADDR_A),
    .READ_DATA_A   (READ_DATA_A),
    .READ_VALID_A  (READ_VALID_A),
    .READ_ENABLE_B (READ_ENABLE_B),
    .READ_ADDR_B   (READ_ADDR_B),
    .READ_DATA_B   (READ_DATA_B),
    .READ_VALID_B  (READ_VALID_B),
    .REGISTERS     (REGISTERS),
    .WRITE_COUNT   (WRITE_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_count = 0;
    exp_a = '0; exp_b = '0; exp_va = 1'b0; exp_vb = 1'b0;
  endtask

  // Apply one cycle of stimulus, advance the model, then sample 1 unit after the edge.
  task automatic do_cycle(input logic we, input logic [2:0] wa, input logic [BITS-1:0] wd,
                          input logic rea, input logic [2:0] raa,
                          input logic reb, input logic [2:0] rab);
    logic commit;
    WRITE_ENABLE = we; WRITE_ADDR = wa; WRITE_DATA = wd;
    READ_ENABLE_A = rea; READ_ADDR_A = raa;
    READ_ENABLE_B = reb; READ_ADDR_B = rab;
    commit = we && !(HW && wa == 3'd0);
    exp_va = rea;
    exp_vb = reb;
    if (rea) exp_a = (commit && wa == raa) ? wd : m_regs[raa];
    if (reb) exp_b = (commit && wa == rab) ? wd : m_regs[rab];
    if (commit) begin
      m_regs[wa] = wd;
      if (m_count < 65535) m_count++;
    end
    @(posedge CLK);
    #1;
    WRITE_ENABLE = 1'b0; READ_ENABLE_A = 1'b0; READ_ENABLE_B = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    n_vec++;
    if (READ_VALID_A !== 1'b0 || READ_DATA_A !== '0 || WRITE_COUNT !== 16'd0 || REGISTERS !== '0) begin
      n_err++;
      $display("FAIL reset_hold: va=%b da=%h cnt=%0d regs=%h, want all 0", READ_VALID_A, READ_DATA_A, WRITE_COUNT, REGISTERS);
    end
    RESET_N = 1'b1;
    do_cycle(1'b0, 3'd0, '0, 1'b1, 3'd5, 1'b1, 3'd7);
    n_vec++;
    if (READ_DATA_A !== 32'd0 || READ_DATA_B !== 32'd0 || READ_VALID_A !== 1'b1 || READ_VALID_B !== 1'b1 || WRITE_COUNT !== 16'd0) begin
      n_err++;
      $display("FAIL reset_read: da=%h db=%h va=%b vb=%b cnt=%0d, want 0 0 1 1 0", READ_DATA_A, READ_DATA_B, READ_VALID_A, READ_VALID_B, WRITE_COUNT);
    end
  endtask

  task automatic test_write_readback();
    do_cycle(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 1'b0, 3'd0);
    n_vec++;
    if (REGISTERS[3] !== 32'hDEADBEEF || WRITE_COUNT !== 16'd1) begin
      n_err++;
      $display("FAIL write_reg3: regs3=%h cnt=%0d, want deadbeef 1", REGISTERS[3], WRITE_COUNT);
    end
    do_cycle(1'b0, 3'd0, '0, 1'b1, 3'd3, 1'b0, 3'd0);
    n_vec++;
    if (READ_DATA_A !== 32'hDEADBEEF || READ_VALID_A !== 1'b1) begin
      n_err++;
      $display("FAIL readback: da=%h va=%b, want deadbeef 1", READ_DATA_A, READ_VALID_A);
    end
  endtask

  task automatic test_bypass();
    do_cycle(1'b1, 3'd6, 32'h12345678, 1'b1, 3'd6, 1'b1, 3'd6);
    n_vec++;
    if (READ_DATA_A !== 32'h12345678 || READ_DATA_B !== 32'h12345678) begin
      n_err++;
      $display("FAIL bypass: da=%h db=%h, want 12345678 both", READ_DATA_A, READ_DATA_B);
    end
    n_vec++;
    if (WRITE_COUNT !== 16'd2 || REGISTERS[6] !== 32'h12345678) begin
      n_err++;
      $display("FAIL bypass_commit: cnt=%0d regs6=%h, want 2 12345678", WRITE_COUNT, REGISTERS[6]);
    end
  endtask

  task automatic test_hardwired_zero();
    do_cycle(1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 3'd0, 1'b0, 3'd0);
    n_vec++;
    if (READ_DATA_A !== 32'd0 || REGISTERS[0] !== 32'd0 || WRITE_COUNT !== 16'd2) begin
      n_err++;
      $display("FAIL hardwired_zero: da=%h regs0=%h cnt=%0d, want 0 0 2", READ_DATA_A, REGISTERS[0], WRITE_COUNT);
    end
  endtask

  task automatic test_hold_valid();
    logic [2:0] want_v;
    logic [2:0] got_v;
    want_v = 3'b100;
    do_cycle(1'b0, 3'd0, '0, 1'b1, 3'd3, 1'b0, 3'd0);
    got_v[2] = READ_VALID_A;
    for (int k = 1; k >= 0; k--) begin
      do_cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, 1'b0, 3'd0);
      got_v[k] = READ_VALID_A;
      n_vec++;
      if (READ_DATA_A !== 32'hDEADBEEF) begin
        n_err++;
        $display("FAIL hold_data: da=%h, want deadbeef", READ_DATA_A);
      end
    end
    n_vec++;
    if (got_v !== want_v) begin
      n_err++;
      $display("FAIL hold_valid_seq: got %b, want %b", got_v, want_v);
    end
  endtask

  task automatic test_random_traffic();
    for (int c = 0; c < 400; c++) begin
      do_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), BITS'($urandom),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      n_vec++;
      if (READ_DATA_A !== exp_a || READ_VALID_A !== exp_va) begin
        n_err++;
        $display("FAIL rand_port_a c=%0d: da=%h va=%b, want %h %b", c, READ_DATA_A, READ_VALID_A, exp_a, exp_va);
      end
      n_vec++;
      if (READ_DATA_B !== exp_b || READ_VALID_B !== exp_vb) begin
        n_err++;
        $display("FAIL rand_port_b c=%0d: db=%h vb=%b, want %h %b", c, READ_DATA_B, READ_VALID_B, exp_b, exp_vb);
      end
      n_vec++;
      if (WRITE_COUNT !== 16'(m_count)) begin
        n_err++;
        $display("FAIL rand_count c=%0d: cnt=%0d, want %0d", c, WRITE_COUNT, m_count);
      end
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (REGISTERS[i] !== m_regs[i]) begin
          n_err++;
          $display("FAIL rand_regs c=%0d e=%0d: got %h, want %h", c, i, REGISTERS[i], m_regs[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_cycle(1'b1, 3'd3, 32'hA5A5A5A5, 1'b1, 3'd3, 1'b0, 3'd0);
    n_vec++;
    if (READ_VALID_A !== 1'b1 || READ_DATA_A !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL async_setup: va=%b da=%h, want 1 a5a5a5a5", READ_VALID_A, READ_DATA_A);
    end
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (READ_VALID_A !== 1'b0 || READ_DATA_A !== '0 || REGISTERS !== '0 || WRITE_COUNT !== 16'd0) begin
      n_err++;
      $display("FAIL async_reset: va=%b da=%h regs=%h cnt=%0d, want all 0", READ_VALID_A, READ_DATA_A, REGISTERS, WRITE_COUNT);
    end
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    do_cycle(1'b1, 3'd2, 32'h0BADF00D, 1'b1, 3'd2, 1'b1, 3'd3);
    n_vec++;
    if (READ_DATA_A !== 32'h0BADF00D || READ_DATA_B !== 32'd0 || WRITE_COUNT !== 16'd1) begin
      n_err++;
      $display("FAIL post_reset: da=%h db=%h cnt=%0d, want 0badf00d 0 1", READ_DATA_A, READ_DATA_B, WRITE_COUNT);
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_bypass();
    test_hardwired_zero();
    test_hold_valid();
    test_random_traffic();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
